// File: rtl/l2_request_arbiter_pkg.sv
// Shared types for the L1-to-L2 request arbiter: LC-3b word/line types,
// arbiter port identifiers, FSM states and the round-robin pick helper.
package l2_request_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } lc3b_arb_port_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } arb_state_t;

    // Under contention the port that was not served last wins.
    function automatic lc3b_arb_port_t pick_port(
        input logic           i_req,
        input logic           d_req,
        input lc3b_arb_port_t last
    );
        lc3b_arb_port_t port;
        if (i_req && d_req) begin
            port = (last == ARB_I) ? ARB_D : ARB_I;
        end else if (d_req) begin
            port = ARB_D;
        end else begin
            port = ARB_I;
        end
        return port;
    endfunction

endpackage

// File: rtl/l2_request_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Counter register: clear, saturating increment, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of the L2 controller, with
// per-port stall-cycle counters. All outputs come straight from registers.
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_read,
    input  logic [15:0]      i_address,
    output logic             i_resp,
    output logic [127:0]     i_rdata,
    input  logic             d_read,
    input  logic             d_write,
    input  logic [15:0]      d_address,
    input  logic [127:0]     d_wdata,
    output logic             d_resp,
    output logic [127:0]     d_rdata,
    output logic             l2_read,
    output logic             l2_write,
    output logic [15:0]      l2_address,
    output logic [127:0]     l2_wdata,
    input  logic             l2_resp,
    input  logic [127:0]     l2_rdata,
    output logic [CNT_W-1:0] i_stall_count,
    output logic [CNT_W-1:0] d_stall_count,
    input  logic             stall_reset
);

    arb_state_t     state_r, state_next_s;
    lc3b_arb_port_t last_grant_r, grant_s;
    logic           i_req_s, d_req_s, start_s, op_write_s;
    lc3b_word       addr_s, addr_r;
    lc3b_line       wdata_s, wdata_r, i_rdata_r, d_rdata_r;
    logic           l2_read_r, l2_write_r, i_resp_r, d_resp_r;

    assign i_req_s = i_read;
    assign d_req_s = d_read | d_write;

    // Next-state decode and grant selection.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        grant_s      = pick_port(i_req_s, d_req_s, last_grant_r);
        op_write_s   = (grant_s == ARB_D) && d_write;
        addr_s       = (grant_s == ARB_D) ? d_address : i_address;
        wdata_s      = (grant_s == ARB_D) ? d_wdata : 128'h0;
        case (state_r)
            ST_IDLE: begin
                if (i_req_s || d_req_s) begin
                    state_next_s = ST_BUSY;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (l2_resp) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request capture, L2 command and L1 response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= ARB_I;
            addr_r       <= 16'h0;
            wdata_r      <= 128'h0;
            l2_read_r    <= 1'b0;
            l2_write_r   <= 1'b0;
            i_resp_r     <= 1'b0;
            d_resp_r     <= 1'b0;
            i_rdata_r    <= 128'h0;
            d_rdata_r    <= 128'h0;
        end else begin
            i_resp_r <= 1'b0;
            d_resp_r <= 1'b0;
            if (start_s) begin
                last_grant_r <= grant_s;
                addr_r       <= addr_s;
                wdata_r      <= wdata_s;
                l2_read_r    <= ~op_write_s;
                l2_write_r   <= op_write_s;
            end else if ((state_r == ST_BUSY) && l2_resp) begin
                // Drop the L2 command in DONE so a combinational hit is not re-issued.
                l2_read_r  <= 1'b0;
                l2_write_r <= 1'b0;
                if (last_grant_r == ARB_D) begin
                    d_resp_r  <= 1'b1;
                    d_rdata_r <= l2_rdata;
                end else begin
                    i_resp_r  <= 1'b1;
                    i_rdata_r <= l2_rdata;
                end
            end else begin
                l2_read_r  <= l2_read_r;
                l2_write_r <= l2_write_r;
            end
        end
    end

    assign l2_read    = l2_read_r;
    assign l2_write   = l2_write_r;
    assign l2_address = addr_r;
    assign l2_wdata   = wdata_r;
    assign i_resp     = i_resp_r;
    assign d_resp     = d_resp_r;
    assign i_rdata    = i_rdata_r;
    assign d_rdata    = d_rdata_r;

    sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_req_s & ~i_resp_r),
        .clr   (stall_reset),
        .count (i_stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (d_req_s & ~d_resp_r),
        .clr   (stall_reset),
        .count (d_stall_count)
    );

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter; a second narrow-counter instance
// exercises stall-counter saturation quickly.
module tb_l2_request_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read, d_read, d_write, l2_resp, stall_reset;
    logic [15:0]  i_address, d_address;
    logic [127:0] d_wdata, l2_rdata;
    logic         i_resp, d_resp, l2_read, l2_write;
    logic [127:0] i_rdata, d_rdata, l2_wdata;
    logic [15:0]  l2_address, i_stall_count, d_stall_count;

    logic         s_d_read;
    logic         s_i_resp, s_d_resp, s_l2_read, s_l2_write;
    logic [127:0] s_i_rdata, s_d_rdata, s_l2_wdata;
    logic [15:0]  s_l2_address;
    logic [3:0]   s_i_stall, s_d_stall;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [127:0] LINE_A5 = {16{8'hA5}};
    localparam logic [127:0] W1      = {4{32'hDEAD_BEEF}};
    localparam logic [127:0] W2      = {4{32'hCAFE_F00D}};
    localparam logic [127:0] R_D     = {4{32'h1111_2222}};
    localparam logic [127:0] R_I     = {4{32'h3333_4444}};
    localparam logic [127:0] R3      = {4{32'h5555_6666}};
    localparam logic [127:0] R4      = {4{32'h7777_8888}};
    localparam logic [127:0] R5      = {4{32'h9999_AAAA}};

    always #5 clk = ~clk;

    l2_request_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_resp(l2_resp), .l2_rdata(l2_rdata),
        .i_stall_count(i_stall_count), .d_stall_count(d_stall_count),
        .stall_reset(stall_reset)
    );

    l2_request_arbiter #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .i_read(1'b0), .i_address(16'h0), .i_resp(s_i_resp), .i_rdata(s_i_rdata),
        .d_read(s_d_read), .d_write(1'b0), .d_address(16'h0), .d_wdata(128'h0),
        .d_resp(s_d_resp), .d_rdata(s_d_rdata),
        .l2_read(s_l2_read), .l2_write(s_l2_write), .l2_address(s_l2_address),
        .l2_wdata(s_l2_wdata), .l2_resp(1'b0), .l2_rdata(128'h0),
        .i_stall_count(s_i_stall), .d_stall_count(s_d_stall),
        .stall_reset(stall_reset)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
        stall_reset = 1'b0; i_address = 16'h0; d_address = 16'h0;
        d_wdata = 128'h0; l2_rdata = 128'h0; s_d_read = 1'b0;

        // Reset state
        #12;
        chk("rst_l2_cmd", {l2_read, l2_write, i_resp, d_resp}, 4'b0000);
        chk("rst_l2_addr", l2_address, 16'h0);
        chk("rst_l2_wdata", l2_wdata, 128'h0);
        chk("rst_rdata", {i_rdata, d_rdata} == 256'h0, 1'b1);
        chk("rst_counts", {i_stall_count, d_stall_count}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        step();

        // I read only, L2 answers in the 4th busy cycle
        i_read = 1'b1; i_address = 16'h1230;
        step();
        chk("a_l2_read_c1", {l2_read, l2_write}, 2'b10);
        chk("a_l2_addr", l2_address, 16'h1230);
        step(); chk("a_l2_read_c2", l2_read, 1'b1);
        step(); chk("a_l2_read_c3", l2_read, 1'b1);
        step(); chk("a_l2_read_c4", l2_read, 1'b1);
        chk("a_no_resp_yet", i_resp, 1'b0);
        l2_resp = 1'b1; l2_rdata = LINE_A5;
        step(); l2_resp = 1'b0; l2_rdata = 128'h0;
        chk("a_done_l2_read", l2_read, 1'b0);
        chk("a_i_resp", {i_resp, d_resp}, 2'b10);
        chk("a_i_rdata", i_rdata, LINE_A5);
        step(); i_read = 1'b0;
        chk("a_resp_pulse", i_resp, 1'b0);
        chk("a_rdata_hold", i_rdata, LINE_A5);
        chk("a_i_stall", i_stall_count, 16'd5);
        chk("a_d_stall", d_stall_count, 16'd0);

        // Ties: D first (last grant I), then I; twice
        for (int r = 0; r < 2; r++) begin
            i_read = 1'b1; i_address = 16'h7770;
            d_write = (r == 0); d_read = (r == 1); d_address = 16'h4560; d_wdata = W1;
            step();
            chk("tie_d_addr", l2_address, 16'h4560);
            chk("tie_d_op", {l2_read, l2_write}, (r == 0) ? 2'b01 : 2'b10);
            chk("tie_d_wdata", l2_wdata, W1);
            l2_resp = 1'b1; l2_rdata = R_D;
            step(); l2_resp = 1'b0;
            chk("tie_d_resp", {i_resp, d_resp, l2_read, l2_write}, 4'b0100);
            chk("tie_d_rdata", d_rdata, R_D);
            d_write = 1'b0; d_read = 1'b0;
            step();
            chk("tie_d_resp_end", d_resp, 1'b0);
            step();
            chk("tie_i_grant", {l2_read, l2_write}, 2'b10);
            chk("tie_i_addr", l2_address, 16'h7770);
            l2_resp = 1'b1; l2_rdata = R_I;
            step(); l2_resp = 1'b0;
            chk("tie_i_resp", {i_resp, d_resp}, 2'b10);
            chk("tie_i_rdata", i_rdata, R_I);
            chk("tie_d_rdata_hold", d_rdata, R_D);
            i_read = 1'b0;
            step();
        end

        // L2 hit in the first busy cycle
        d_read = 1'b1; d_address = 16'h0100;
        step();
        chk("hit_l2_read", l2_read, 1'b1);
        l2_resp = 1'b1; l2_rdata = R3;
        step(); l2_resp = 1'b0;
        chk("hit_done_cmd", {l2_read, l2_write}, 2'b00);
        chk("hit_d_resp", d_resp, 1'b1);
        chk("hit_d_rdata", d_rdata, R3);
        d_read = 1'b0;
        step();
        chk("hit_single_resp", {d_resp, l2_read}, 2'b00);
        step();
        chk("hit_no_reissue", {d_resp, l2_read, l2_write}, 3'b000);

        // D stalls behind a 10-cycle I transaction (last grant D -> I wins)
        stall_reset = 1'b1;
        step();
        stall_reset = 1'b0;
        i_read = 1'b1; i_address = 16'h2000; d_read = 1'b1; d_address = 16'h3000;
        step();
        chk("st_i_first", l2_address, 16'h2000);
        repeat (7) step();
        l2_resp = 1'b1; l2_rdata = R4;
        step(); l2_resp = 1'b0;
        chk("st_i_resp", i_resp, 1'b1);
        step(); i_read = 1'b0;
        step();
        chk("st_d_grant", {l2_read, l2_address}, {1'b1, 16'h3000});
        l2_resp = 1'b1; l2_rdata = R5;
        step(); l2_resp = 1'b0;
        chk("st_d_resp", d_resp, 1'b1);
        step(); d_read = 1'b0;
        chk("st_d_count", d_stall_count, 16'd12);
        chk("st_i_count", i_stall_count, 16'd9);
        stall_reset = 1'b1;
        step(); stall_reset = 1'b0;
        chk("st_clear", {i_stall_count, d_stall_count}, 32'h0);

        // d_read & d_write -> write; request dropped while busy
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h5550; d_wdata = W2;
        step();
        chk("rw_op_write", {l2_read, l2_write}, 2'b01);
        chk("rw_wdata", l2_wdata, W2);
        d_read = 1'b0; d_write = 1'b0;
        step();
        chk("rw_no_abort", l2_write, 1'b1);
        step();
        l2_resp = 1'b1;
        step(); l2_resp = 1'b0;
        chk("rw_d_resp", d_resp, 1'b1);
        step();
        chk("rw_resp_once", d_resp, 1'b0);
        step();
        chk("rw_idle", {d_resp, l2_read, l2_write}, 3'b000);

        // Async reset in the middle of a busy transaction
        i_read = 1'b1; i_address = 16'h0ABC;
        step();
        chk("ar_busy", l2_read, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cmd", {l2_read, l2_write, i_resp, d_resp}, 4'b0000);
        chk("ar_addr", l2_address, 16'h0);
        chk("ar_rdata", {i_rdata, d_rdata} == 256'h0, 1'b1);
        chk("ar_counts", {i_stall_count, d_stall_count}, 32'h0);
        d_read = 1'b1; d_address = 16'h6660;
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("ar_d_first", {l2_read, l2_address}, {1'b1, 16'h6660});
        i_read = 1'b0;
        l2_resp = 1'b1;
        step(); l2_resp = 1'b0;
        chk("ar_d_resp", d_resp, 1'b1);
        d_read = 1'b0;
        step(); step();

        // Saturation and clear priority on a 4-bit counter instance
        s_d_read = 1'b1;
        repeat (20) step();
        chk("sat_all_ones", s_d_stall, 4'hF);
        step();
        chk("sat_stays", s_d_stall, 4'hF);
        chk("sat_quiet", {s_i_resp, |s_i_rdata, |s_d_rdata, s_l2_write, |s_l2_address,
                          |s_l2_wdata, |s_i_stall, s_d_resp, s_l2_read}, 9'b000000001);
        stall_reset = 1'b1;
        step(); stall_reset = 1'b0;
        chk("sat_clr_wins", s_d_stall, 4'h0);
        step();
        chk("sat_restart", s_d_stall, 4'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
